// File: rtl/lcd_pattern_sequencer_if.sv
// LCD panel bus: data enable, syncs, RGB565 pixel and the pattern mode on display.
// Pixel valid/ready: RGB is meaningful only when LCD_DE=1; the panel never stalls, so there is no ready.
interface lcd_pattern_sequencer_if;
  logic       LCD_DE;
  logic       LCD_HSYNC;
  logic       LCD_VSYNC;
  logic [4:0] LCD_R;
  logic [5:0] LCD_G;
  logic [4:0] LCD_B;
  logic [1:0] Mode;

  modport master (output LCD_DE, LCD_HSYNC, LCD_VSYNC, LCD_R, LCD_G, LCD_B, Mode);
  modport slave  (input  LCD_DE, LCD_HSYNC, LCD_VSYNC, LCD_R, LCD_G, LCD_B, Mode);
endinterface

// File: rtl/lcd_pattern_sequencer.sv
// RGB565 LCD timing generator with four run-time test patterns selected by a
// debounced push button; mode changes are applied only at the frame boundary.
module lcd_pattern_sequencer #(
  parameter int H_ACTIVE   = 800,
  parameter int H_FRONT    = 210,
  parameter int H_SYNC     = 1,
  parameter int H_BACK     = 182,
  parameter int V_ACTIVE   = 480,
  parameter int V_FRONT    = 45,
  parameter int V_SYNC     = 5,
  parameter int V_BACK     = 6,
  parameter bit SYNC_POL   = 1'b0,
  parameter int NUM_BARS   = 8,
  parameter int CHECK_LOG2 = 5,
  parameter int GRAY_SHIFT = 3,
  parameter int DEB_CYCLES = 500000,
  parameter bit BTN_ACTIVE = 1'b1
) (
  input  logic                    PixelClk,
  input  logic                    Reset_Button,
  input  logic                    User_Button,
  lcd_pattern_sequencer_if.master lcd
);
  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
  // Counters are widened so the gray and checker bit selects always exist.
  localparam int HW    = max2($clog2(H_TOTAL), max2(GRAY_SHIFT + 6, CHECK_LOG2 + 1));
  localparam int VW    = max2($clog2(V_TOTAL), CHECK_LOG2 + 1);
  localparam int BAR_W = H_ACTIVE / NUM_BARS;
  localparam int BW    = max2($clog2(BAR_W + 1), 1);
  localparam int DW    = max2($clog2(DEB_CYCLES + 1), 1);

  localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT    = HW'(H_ACTIVE);
  localparam logic [HW-1:0] HS_START = HW'(H_ACTIVE + H_FRONT);
  localparam logic [HW-1:0] HS_END   = HW'(H_ACTIVE + H_FRONT + H_SYNC);
  localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT    = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VS_START = VW'(V_ACTIVE + V_FRONT);
  localparam logic [VW-1:0] VS_END   = VW'(V_ACTIVE + V_FRONT + V_SYNC);
  localparam logic [BW-1:0] BAR_CNT_LAST = BW'(BAR_W - 1);
  localparam logic [2:0]    BAR_IDX_LAST = 3'(NUM_BARS - 1);
  localparam logic [DW-1:0] DEB_LAST     = DW'(DEB_CYCLES - 1);

  logic [HW-1:0] h_cnt;
  logic [VW-1:0] v_cnt;
  logic [BW-1:0] bar_cnt;
  logic [2:0]    bar_idx;
  logic [1:0]    btn_sync;
  logic          btn_level;
  logic [DW-1:0] deb_cnt;
  logic [1:0]    pending;
  logic [1:0]    mode;

  logic       h_last, frame_last;
  logic       de_c, hs_c, vs_c;
  logic       btn_pressed, deb_flip, press_evt;
  logic [5:0] gray;
  logic       check_on;
  logic [4:0] r_c;
  logic [5:0] g_c;
  logic [4:0] b_c;

  assign h_last     = (h_cnt == H_LAST);
  assign frame_last = h_last && (v_cnt == V_LAST);
  assign de_c       = (h_cnt < H_ACT) && (v_cnt < V_ACT);
  assign hs_c       = (h_cnt >= HS_START) && (h_cnt < HS_END);
  assign vs_c       = (v_cnt >= VS_START) && (v_cnt < VS_END);

  // btn_level is held in "pressed" polarity regardless of BTN_ACTIVE.
  assign btn_pressed = (btn_sync[1] == BTN_ACTIVE);
  assign deb_flip    = (btn_pressed != btn_level) && (deb_cnt == DEB_LAST);
  assign press_evt   = deb_flip && btn_pressed;

  assign gray     = h_cnt[GRAY_SHIFT+5:GRAY_SHIFT];
  assign check_on = h_cnt[CHECK_LOG2] ^ v_cnt[CHECK_LOG2];

  // Bar palette bits: R off for idx[1], G off for idx[2], B off for idx[0].
  always_comb begin
    r_c = '0;
    g_c = '0;
    b_c = '0;
    case (mode)
      2'd0: begin
        r_c = {5{~bar_idx[1]}};
        g_c = {6{~bar_idx[2]}};
        b_c = {5{~bar_idx[0]}};
      end
      2'd1: begin
        g_c = gray;
        r_c = gray[5:1];
        b_c = gray[5:1];
      end
      2'd2: begin
        r_c = {5{check_on}};
        g_c = {6{check_on}};
        b_c = {5{check_on}};
      end
      default: begin
        r_c = '1;
        g_c = '1;
        b_c = '1;
      end
    endcase
    if (!de_c) begin
      r_c = '0;
      g_c = '0;
      b_c = '0;
    end
  end

  always_ff @(posedge PixelClk) begin
    if (Reset_Button) begin
      h_cnt         <= '0;
      v_cnt         <= '0;
      bar_cnt       <= '0;
      bar_idx       <= '0;
      btn_sync      <= {2{~BTN_ACTIVE}};
      btn_level     <= 1'b0;
      deb_cnt       <= '0;
      pending       <= '0;
      mode          <= '0;
      lcd.LCD_DE    <= 1'b0;
      lcd.LCD_HSYNC <= ~SYNC_POL;
      lcd.LCD_VSYNC <= ~SYNC_POL;
      lcd.LCD_R     <= '0;
      lcd.LCD_G     <= '0;
      lcd.LCD_B     <= '0;
    end else begin
      h_cnt <= h_last ? '0 : h_cnt + 1'b1;
      if (h_last) v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;

      // Bar index tracks h_cnt without a divider; the last bar absorbs the remainder.
      if (h_last) begin
        bar_cnt <= '0;
        bar_idx <= '0;
      end else if (bar_cnt == BAR_CNT_LAST) begin
        bar_cnt <= '0;
        if (bar_idx != BAR_IDX_LAST) bar_idx <= bar_idx + 1'b1;
      end else begin
        bar_cnt <= bar_cnt + 1'b1;
      end

      btn_sync <= {btn_sync[0], User_Button};
      if (btn_pressed != btn_level) begin
        if (deb_flip) begin
          btn_level <= btn_pressed;
          deb_cnt   <= '0;
        end else begin
          deb_cnt <= deb_cnt + 1'b1;
        end
      end else begin
        deb_cnt <= '0;
      end

      // A press on the frame-last clock lands in pending after mode has sampled it.
      if (press_evt) pending <= pending + 2'd1;
      if (frame_last) mode <= pending;

      lcd.LCD_DE    <= de_c;
      lcd.LCD_HSYNC <= hs_c ? SYNC_POL : ~SYNC_POL;
      lcd.LCD_VSYNC <= vs_c ? SYNC_POL : ~SYNC_POL;
      lcd.LCD_R     <= r_c;
      lcd.LCD_G     <= g_c;
      lcd.LCD_B     <= b_c;
    end
  end

  assign lcd.Mode = mode;
endmodule

// File: tb/tb_lcd_pattern_sequencer.sv
// Directed bench for lcd_pattern_sequencer on a tiny 22x7 raster, plus an
// H_ACTIVE=18 instance to exercise the wide last colour bar.
module tb_lcd_pattern_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic btn = 1'b0;

  lcd_pattern_sequencer_if bus ();
  lcd_pattern_sequencer_if bus18 ();

  lcd_pattern_sequencer #(
    .H_ACTIVE(16), .H_FRONT(2), .H_SYNC(2), .H_BACK(2),
    .V_ACTIVE(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
    .SYNC_POL(1'b0), .NUM_BARS(4), .CHECK_LOG2(1), .GRAY_SHIFT(0),
    .DEB_CYCLES(4), .BTN_ACTIVE(1'b1)
  ) dut (
    .PixelClk(clk), .Reset_Button(rst), .User_Button(btn), .lcd(bus)
  );

  lcd_pattern_sequencer #(
    .H_ACTIVE(18), .H_FRONT(2), .H_SYNC(2), .H_BACK(2),
    .V_ACTIVE(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
    .SYNC_POL(1'b0), .NUM_BARS(4), .CHECK_LOG2(1), .GRAY_SHIFT(0),
    .DEB_CYCLES(4), .BTN_ACTIVE(1'b1)
  ) dut18 (
    .PixelClk(clk), .Reset_Button(rst), .User_Button(1'b0), .lcd(bus18)
  );

  // Clock / reset block
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int th, tv, th18, tv18;
  int frame_de;
  logic [1:0] frame_mode;
  logic [1:0] exp_pending;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at h=%0d v=%0d: got %0h expected %0h", tag, th, tv, got, exp);
    end
  endtask

  // Hand-derived colours for the 16-wide raster (4 bars of 4 pixels).
  function automatic logic [15:0] exp_rgb(input logic [1:0] m, input int h, input int v, input int bar);
    logic [15:0] c;
    case (m)
      2'd0: begin
        case (bar)
          0:       c = {5'd31, 6'd63, 5'd31};
          1:       c = {5'd31, 6'd63, 5'd0};
          2:       c = {5'd0,  6'd63, 5'd31};
          default: c = {5'd0,  6'd63, 5'd0};
        endcase
      end
      2'd1:    c = {5'(h >> 1), 6'(h), 5'(h >> 1)};
      2'd2:    c = ((((h / 2) % 2) ^ ((v / 2) % 2)) != 0) ? 16'hFFFF : 16'h0000;
      default: c = 16'hFFFF;
    endcase
    return c;
  endfunction

  task automatic check_reset_outputs();
    check("rst_de", bus.LCD_DE, 1'b0);
    check("rst_hsync", bus.LCD_HSYNC, 1'b1);
    check("rst_vsync", bus.LCD_VSYNC, 1'b1);
    check("rst_rgb", {bus.LCD_R, bus.LCD_G, bus.LCD_B}, 16'h0000);
    check("rst_mode", bus.Mode, 2'd0);
  endtask

  // Driver/scoreboard step: each negedge compares outputs against the raster position.
  task automatic run(input int n);
    logic exp_de, e18;
    int bar18;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      exp_de = (th < 16) && (tv < 4);
      check("de", bus.LCD_DE, exp_de);
      check("hsync", bus.LCD_HSYNC, !((th >= 18) && (th < 20)));
      check("vsync", bus.LCD_VSYNC, tv != 5);
      check("rgb", {bus.LCD_R, bus.LCD_G, bus.LCD_B},
            exp_de ? exp_rgb(frame_mode, th, tv, th / 4) : 16'h0000);
      if (exp_de) check("mode", bus.Mode, frame_mode);
      e18   = (th18 < 18) && (tv18 < 4);
      bar18 = (th18 / 4 > 3) ? 3 : th18 / 4;
      check("rgb18", {bus18.LCD_R, bus18.LCD_G, bus18.LCD_B},
            e18 ? exp_rgb(2'd0, th18, tv18, bar18) : 16'h0000);
      if (bus.LCD_DE) frame_de++;

      th++;
      if (th == 22) begin
        th = 0;
        tv++;
        if (tv == 7) begin
          tv = 0;
          check("de_per_frame", frame_de, 64);
          frame_de   = 0;
          frame_mode = exp_pending;
        end
      end
      th18++;
      if (th18 == 24) begin
        th18 = 0;
        tv18 = (tv18 == 6) ? 0 : tv18 + 1;
      end
    end
  endtask

  task automatic finish_frame();
    run(154 - (tv * 22 + th));
  endtask

  task automatic press();
    btn = 1'b1;
    run(10);
    btn = 1'b0;
    run(12);
    exp_pending = exp_pending + 2'd1;
  endtask

  task automatic restart_model();
    th = 0; tv = 0; th18 = 0; tv18 = 0;
    frame_de = 0;
    frame_mode = 2'd0;
    exp_pending = 2'd0;
  endtask

  initial begin
    restart_model();
    rst = 1'b1;
    btn = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs();
    rst = 1'b0;

    // Two frames of mode 0 timing and colour bars
    run(308);

    // 3-clock glitch is rejected; a 10-clock hold mid-frame selects mode 1 next frame
    btn = 1'b1;
    run(3);
    btn = 1'b0;
    run(10);
    press();
    finish_frame();
    run(154);

    // Step to mode 2, then two presses in the checkerboard frame wrap 2->3->0
    press();
    finish_frame();
    press();
    press();
    finish_frame();

    // Three presses to reach solid white, then reset mid-line at (7,2)
    press();
    press();
    press();
    finish_frame();
    run(51);
    rst = 1'b1;
    @(negedge clk);
    check_reset_outputs();
    rst = 1'b0;
    restart_model();
    run(164);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/lcd_pattern_sequencer.md
Name: lcd_pattern_sequencer

Overview:
- Parametrised RGB565 LCD timing generator with a run-time selectable test-pattern engine, clocked from the PLL pixel clock (CLK_PIX).
- Replaces per-pattern modules that are swapped by editing the top level. One instance drives LCD_DE/HSYNC/VSYNC/RGB directly.
- The debounced User_Button cycles through the patterns. A mode change takes effect only at a frame boundary.

Parameters:
- H_ACTIVE, 800, active pixels per line
- H_FRONT, 210, horizontal front porch (clocks)
- H_SYNC, 1, HSYNC pulse width (clocks, >=1)
- H_BACK, 182, horizontal back porch (clocks)
- V_ACTIVE, 480, active lines per frame
- V_FRONT, 45, vertical front porch (lines)
- V_SYNC, 5, VSYNC pulse width (lines, >=1)
- V_BACK, 6, vertical back porch (lines)
- SYNC_POL, 0, asserted level of HSYNC/VSYNC
- NUM_BARS, 8, number of colour bars in mode 0 (2..8)
- CHECK_LOG2, 5, checkerboard square size = 2^CHECK_LOG2 pixels
- GRAY_SHIFT, 3, grayscale ramp step = 2^GRAY_SHIFT pixels per level
- DEB_CYCLES, 500000, clocks the button must be stable before a level change is accepted
- BTN_ACTIVE, 1, pressed level of User_Button

Ports:
- PixelClk, in, 1, pixel clock; the only clock
- Reset_Button, in, 1, synchronous, active-high reset
- User_Button, in, 1, raw asynchronous push button
- LCD_DE, out, 1, data enable
- LCD_HSYNC, out, 1, horizontal sync
- LCD_VSYNC, out, 1, vertical sync
- LCD_R, out, 5, red
- LCD_G, out, 6, green
- LCD_B, out, 5, blue
- Mode, out, 2, pattern currently displayed

Behaviour:
- Counters:
  - H_TOTAL = H_ACTIVE+H_FRONT+H_SYNC+H_BACK; V_TOTAL likewise.
  - h_cnt counts 0..H_TOTAL-1 and wraps to 0.
  - v_cnt increments when h_cnt wraps, and itself wraps at V_TOTAL-1.
- Region order is: active, front porch, sync, back porch.
  - de_c = (h_cnt < H_ACTIVE) && (v_cnt < V_ACTIVE).
  - hs_c asserted for H_ACTIVE+H_FRONT <= h_cnt < H_ACTIVE+H_FRONT+H_SYNC.
  - vs_c asserted for the analogous v_cnt range, for whole lines.
- Output timing:
  - All outputs are registered, with exactly 1 clock latency from the counter state.
  - DE, syncs and RGB are always mutually aligned.
  - RGB = 0 whenever DE = 0.
- Reset (any cycle, including mid-frame):
  - h_cnt = v_cnt = 0; LCD_DE = 0; HSYNC = VSYNC = ~SYNC_POL; RGB = 0; Mode = 0; pending mode = 0.
  - The debounce counter and debounced level are cleared to the not-pressed state.
  - First clock after release: outputs reflect (h,v) = (0,0), i.e. DE = 1.
- Button path:
  - 2-flop synchroniser feeds the debounce logic.
  - The debounced level changes only after the synchronised input differs from it for DEB_CYCLES consecutive clocks. Any bounce restarts the count.
  - A not-pressed -> pressed transition of the debounced level increments the pending mode, wrapping 3 -> 0.
- Mode update:
  - Mode <= pending at the clock where h_cnt = H_TOTAL-1 and v_cnt = V_TOTAL-1, i.e. before the next frame's first pixel.
  - Multiple presses within one frame accumulate; only the final value is applied.
  - If a press lands on that same clock, it is applied at the next frame.
- Mode 0, colour bars:
  - BAR_W = H_ACTIVE/NUM_BARS (integer). A bar index increments each BAR_W pixels.
  - The index saturates at NUM_BARS-1, so the last bar absorbs the remainder.
  - Palette by index (R,G,B): 0 white (31,63,31), 1 yellow (31,63,0), 2 cyan (0,63,31), 3 green (0,63,0), 4 magenta (31,0,31), 5 red (31,0,0), 6 blue (0,0,31), 7 black (0,0,0).
  - No divider: use a within-bar counter reset on each line.
- Mode 1, grayscale:
  - g = h_cnt[GRAY_SHIFT+5:GRAY_SHIFT] (6 bits, wraps every 64 levels).
  - G = g; R = B = g[5:1].
- Mode 2, checkerboard:
  - White when h_cnt[CHECK_LOG2] XOR v_cnt[CHECK_LOG2] = 1, else black.
- Mode 3: solid white.

Test Plan:
Bench parameters: H 16/2/2/2 (H_TOTAL 22), V 4/1/1/1 (V_TOTAL 7), NUM_BARS 4, CHECK_LOG2 1, GRAY_SHIFT 0, DEB_CYCLES 4, SYNC_POL 0.
1. Release reset, run 2 frames:
   - DE high 16 of every 22 clocks on lines 0-3, 64 DE clocks per 154-clock frame.
   - HSYNC low exactly 2 clocks starting 18 clocks after each line's first DE.
   - VSYNC low for 22 clocks, on line 5.
   - DE rises 1 clock after reset release.
2. Mode 0 -> RGB sequence per line: 4x(31,63,31), 4x(31,63,0), 4x(0,63,31), 4x(0,63,0); RGB = 0 during blanking.
   - Repeat with H_ACTIVE 18: the last bar is 6 pixels wide.
3. Button:
   - Pulse high 3 clocks -> no change.
   - Hold 10 clocks mid-frame -> Mode stays 0 until the frame wraps, then 1.
   - Line 0 pixels show G = 0,1,...,15 and R = 0,0,1,1,...
4. Two clean presses in one frame starting from mode 2 -> next frame Mode = 0 (2->3->0), solid-white frame skipped.
5. Mode 2 -> line 0 pixel pattern black,black,white,white,...; line 2 pattern inverted.
6. Assert reset mid-line at h = 7, v = 2 in mode 3 -> next clock: DE = 0, syncs high, RGB = 0, Mode = 0; timing restarts from (0,0).
